// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM sequencer: mode encodings and a
// constant-friendly ceiling log2.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_STEP   = 2'd1,
      MODE_FADE   = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadowed duty register, 1-LSB-per-period fade ramp and
// a registered comparator against the shared period counter.
module pwm_channel
   import led_pkg::*;
#(
   parameter int DUTY_W = 8
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              en,
   input  logic              tick,
   input  mode_e             mode,
   input  logic [DUTY_W-1:0] target,
   input  logic [DUTY_W-1:0] cnt,
   output logic              pwm,
   output logic              at_target
);

   logic [DUTY_W-1:0] duty;
   logic              pwm_r;

   assign at_target = (duty == target);
   assign pwm       = pwm_r & en;

   // Duty only moves on the period tick so a period never sees two duty values.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         duty <= '0;
      end else if (tick) begin
         if (mode == MODE_FADE) begin
            if (duty < target)      duty <= duty + 1'b1;
            else if (duty > target) duty <= duty - 1'b1;
         end else begin
            duty <= target;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) pwm_r <= 1'b0;
      else         pwm_r <= en && (cnt < duty);
   end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Multi-channel PWM colour sequencer: colour table, period counter, dwell
// counter and step index driving CH pwm_channel instances.
module rgb_pwm_sequencer
   import led_pkg::*;
#(
   parameter int CH      = 3,
   parameter int DUTY_W  = 8,
   parameter int STEPS   = 8,
   parameter int DWELL_W = 16
) (
   input  logic                      CLK,
   input  logic                      RESETN,
   input  logic                      EN,
   input  logic [1:0]                MODE,
   input  logic [clog2(STEPS)-1:0]   LAST_STEP,
   input  logic [DWELL_W-1:0]        DWELL,
   input  logic                      WR_EN,
   input  logic [clog2(STEPS)-1:0]   WR_ADDR,
   input  logic [CH*DUTY_W-1:0]      WR_DATA,
   output logic [CH-1:0]             PWM,
   output logic [clog2(STEPS)-1:0]   STEP_IDX,
   output logic                      PERIOD_TICK
);

   localparam int IDX_W = clog2(STEPS);
   localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'((1 << DUTY_W) - 2);

   logic [CH*DUTY_W-1:0] tbl [STEPS];
   logic [CH*DUTY_W-1:0] target;
   logic [DUTY_W-1:0]    cnt;
   logic [DWELL_W-1:0]   dwell;
   logic [DWELL_W-1:0]   dwell_lim;
   logic [1:0]           mode_prev;
   mode_e                mode_eff;
   logic [CH-1:0]        at_vec;
   logic                 tick;
   logic                 dwell_en;
   logic                 advance;
   logic [IDX_W-1:0]     next_idx;

   assign target      = tbl[STEP_IDX];
   assign tick        = EN && (cnt == CNT_LAST);
   assign PERIOD_TICK = tick;
   assign mode_eff    = (MODE == 2'd3) ? MODE_STATIC : mode_e'(MODE);
   assign dwell_lim   = (DWELL == '0) ? '0 : DWELL - DWELL_W'(1);

   // Fade only burns dwell once every channel has landed on its target.
   always_comb begin
      dwell_en = 1'b0;
      if (tick) begin
         dwell_en = (mode_eff == MODE_STEP) ||
                    ((mode_eff == MODE_FADE) && (&at_vec));
      end
      advance  = dwell_en && (dwell >= dwell_lim);
      next_idx = (STEP_IDX >= LAST_STEP) ? '0 : STEP_IDX + 1'b1;
   end

   // A tick in the same clock as a write still reads the old entry.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         for (int i = 0; i < STEPS; i++) tbl[i] <= '0;
      end else if (WR_EN) begin
         tbl[WR_ADDR] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN)               cnt <= '0;
      else if (!EN)              cnt <= '0;
      else if (cnt == CNT_LAST)  cnt <= '0;
      else                       cnt <= cnt + 1'b1;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         dwell     <= '0;
         STEP_IDX  <= '0;
         mode_prev <= 2'd0;
      end else begin
         mode_prev <= MODE;
         if (MODE != mode_prev) dwell <= '0;
         else if (advance)      dwell <= '0;
         else if (dwell_en)     dwell <= dwell + 1'b1;
         if (advance) STEP_IDX <= next_idx;
      end
   end

   for (genvar k = 0; k < CH; k++) begin : g_ch
      pwm_channel #(.DUTY_W(DUTY_W)) u_ch (
         .CLK       (CLK),
         .RESETN    (RESETN),
         .en        (EN),
         .tick      (tick),
         .mode      (mode_eff),
         .target    (target[k*DUTY_W +: DUTY_W]),
         .cnt       (cnt),
         .pwm       (PWM[k]),
         .at_target (at_vec[k])
      );
   end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Scoreboard bench: stimulus queues per-period expectations (high clocks per
// channel, step index at the tick); a negedge monitor measures and compares.
`timescale 1ns/1ps
module tb_rgb_pwm_sequencer;

   logic        CLK = 1'b0;
   logic        RESETN = 1'b0;
   logic        EN = 1'b0;
   logic [1:0]  MODE = 2'd0;
   logic [2:0]  LAST_STEP = 3'd0;
   logic [15:0] DWELL = 16'd1;
   logic        WR_EN = 1'b0;
   logic [2:0]  WR_ADDR = 3'd0;
   logic [23:0] WR_DATA = 24'd0;
   logic [2:0]  PWM;
   logic [2:0]  STEP_IDX;
   logic        PERIOD_TICK;

   rgb_pwm_sequencer #(.CH(3), .DUTY_W(8), .STEPS(8), .DWELL_W(16)) dut (
      .CLK(CLK), .RESETN(RESETN), .EN(EN), .MODE(MODE), .LAST_STEP(LAST_STEP),
      .DWELL(DWELL), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .PWM(PWM), .STEP_IDX(STEP_IDX), .PERIOD_TICK(PERIOD_TICK)
   );

   always #5 CLK = ~CLK;

   typedef struct { int h0; int h1; int h2; int idx; } rec_t;
   rec_t q[$];
   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void push(input int a, input int b, input int c, input int idx);
      rec_t r;
      r.h0 = a; r.h1 = b; r.h2 = c; r.idx = idx;
      q.push_back(r);
   endfunction

   // Monitor: a period's window is 255 samples ending one clock after its tick.
   int  acc [3];
   bit  close_nxt = 0;
   bit  have_prev = 0;
   int  gap = 0;
   int  idx_s = 0;
   always @(negedge CLK) begin
      if (!RESETN || !EN) begin
         for (int k = 0; k < 3; k++) acc[k] = 0;
         close_nxt = 0; have_prev = 0; gap = 0;
      end else begin
         for (int k = 0; k < 3; k++) acc[k] += int'(PWM[k]);
         gap++;
         if (close_nxt) begin
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_period: got a period with idx %0d, expected none", idx_s);
            end else begin
               rec_t r;
               r = q.pop_front();
               chk("ch0_high_clocks", acc[0], r.h0);
               chk("ch1_high_clocks", acc[1], r.h1);
               chk("ch2_high_clocks", acc[2], r.h2);
               chk("step_idx", idx_s, r.idx);
            end
            for (int k = 0; k < 3; k++) acc[k] = 0;
            close_nxt = 0;
         end
         if (PERIOD_TICK) begin
            if (have_prev) chk("tick_gap", gap, 255);
            have_prev = 1; gap = 0; close_nxt = 1; idx_s = int'(STEP_IDX);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wr(input int addr, input int r, input int g, input int b);
      WR_EN = 1'b1; WR_ADDR = 3'(addr); WR_DATA = {8'(b), 8'(g), 8'(r)};
      step(1);
      WR_EN = 1'b0;
   endtask

   task automatic do_reset();
      RESETN = 1'b0; EN = 1'b0; WR_EN = 1'b0; MODE = 2'd0;
      LAST_STEP = 3'd0; DWELL = 16'd1;
      step(3);
      RESETN = 1'b1;
      step(1);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge CLK);
         n++;
      end
      #1;
      if (q.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout: got %0d periods outstanding, expected 0", q.size());
         q.delete();
      end
      EN = 1'b0;
   endtask

   task automatic wait_ticks(input int want, output int seen);
      seen = 0;
      for (int i = 0; i < 3000 && seen < want; i++) begin
         @(posedge CLK); #1;
         if (PERIOD_TICK) seen++;
      end
   endtask

   initial begin
      int nt;
      int n;

      do_reset();
      chk("reset_pwm", int'(PWM), 0);
      chk("reset_step_idx", int'(STEP_IDX), 0);
      chk("reset_tick", int'(PERIOD_TICK), 0);

      // STATIC: R full on, G off, B half
      wr(0, 255, 0, 128);
      MODE = 2'd0;
      push(0, 0, 0, 0); push(255, 0, 128, 0); push(255, 0, 128, 0);
      EN = 1'b1;
      drain(2000);

      // STEP through entries 0..2 with 3 periods each, then DWELL=0
      do_reset();
      wr(0, 10, 20, 30); wr(1, 40, 50, 60); wr(2, 70, 80, 90); wr(3, 1, 1, 1);
      LAST_STEP = 3'd2; DWELL = 16'd3; MODE = 2'd1;
      push(0, 0, 0, 0);    push(10, 20, 30, 0); push(10, 20, 30, 0);
      push(10, 20, 30, 1); push(40, 50, 60, 1); push(40, 50, 60, 1);
      push(40, 50, 60, 2); push(70, 80, 90, 2); push(70, 80, 90, 2);
      push(70, 80, 90, 0);
      EN = 1'b1;
      drain(4000);
      DWELL = 16'd0;
      push(10, 20, 30, 0); push(10, 20, 30, 1); push(40, 50, 60, 2); push(70, 80, 90, 0);
      EN = 1'b1;
      drain(2000);

      // FADE channel 0 up to 10, dwell 2, then fade toward entry 1
      do_reset();
      wr(0, 10, 0, 0); wr(1, 5, 3, 0);
      LAST_STEP = 3'd1; DWELL = 16'd2; MODE = 2'd2;
      for (int i = 0; i < 11; i++) push(i, 0, 0, 0);
      push(10, 0, 0, 0);
      push(10, 0, 0, 1); push(9, 1, 0, 1); push(8, 2, 0, 1); push(7, 3, 0, 1);
      push(6, 3, 0, 1);  push(5, 3, 0, 1); push(5, 3, 0, 1);
      push(5, 3, 0, 0);  push(6, 2, 0, 0);
      EN = 1'b1;
      drain(7000);

      // Write the active entry on the tick clock
      do_reset();
      wr(0, 100, 0, 0);
      push(0, 0, 0, 0); push(100, 0, 0, 0); push(100, 0, 0, 0); push(200, 0, 0, 0);
      EN = 1'b1;
      wait_ticks(2, nt);
      chk("tick_seen_before_write", nt, 2);
      WR_EN = 1'b1; WR_ADDR = 3'd0; WR_DATA = {8'd0, 8'd0, 8'd200};
      step(1);
      WR_EN = 1'b0;
      drain(2000);

      // EN drop mid-period, then re-enable
      do_reset();
      wr(0, 50, 200, 255);
      push(0, 0, 0, 0); push(50, 200, 255, 0);
      EN = 1'b1;
      wait_ticks(2, nt);
      chk("tick_seen_before_en_drop", nt, 2);
      step(100);
      chk("pwm_high_before_drop", int'(PWM), 3'b110);
      EN = 1'b0;
      #1;
      chk("pwm_off_on_en_drop", int'(PWM), 0);
      chk("tick_off_on_en_drop", int'(PERIOD_TICK), 0);
      step(20);
      push(50, 200, 255, 0); push(50, 200, 255, 0);
      EN = 1'b1;
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge CLK);
         n++;
         if (PERIOD_TICK) break;
      end
      chk("reenable_first_tick", n, 255);
      drain(2000);

      // Asynchronous reset mid-fade
      do_reset();
      wr(0, 2, 2, 2); wr(1, 200, 200, 200);
      LAST_STEP = 3'd1; DWELL = 16'd1; MODE = 2'd2;
      push(0, 0, 0, 0); push(1, 1, 1, 0); push(2, 2, 2, 0); push(2, 2, 2, 1); push(3, 3, 3, 1);
      EN = 1'b1;
      drain(3000);
      EN = 1'b1;
      step(1);
      chk("pwm_high_before_reset", int'(PWM), 7);
      chk("step_idx_before_reset", int'(STEP_IDX), 1);
      #2;
      RESETN = 1'b0;
      #1;
      chk("async_reset_pwm", int'(PWM), 0);
      chk("async_reset_step_idx", int'(STEP_IDX), 0);
      chk("async_reset_tick", int'(PERIOD_TICK), 0);
      EN = 1'b0;
      step(2);
      RESETN = 1'b1;
      MODE = 2'd0;
      step(1);
      push(0, 0, 0, 0); push(0, 0, 0, 0);
      EN = 1'b1;
      drain(2000);

      step(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
